// File: rtl/alu_sequencer.sv
// Issue/writeback controller for the registered 8-bit ALU: reads operands from a
// local register file, holds them through EXEC, and writes back result/flags in WB.
module alu_sequencer #(
    parameter int unsigned NREGS   = 8,
    parameter int unsigned ALU_LAT = 1,
    parameter int unsigned MUL_LAT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [3:0] instr_op,
    input  logic [2:0] instr_rd,
    input  logic [2:0] instr_rs1,
    input  logic [2:0] instr_rs2,
    input  logic       ld_valid,
    input  logic [2:0] ld_addr,
    input  logic [7:0] ld_data,
    output logic [3:0] alu_fsl,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic [7:0] alu_result,
    input  logic [7:0] alu_mul_high,
    input  logic [3:0] alu_sreg,
    output logic [3:0] flags,
    output logic       done,
    input  logic [2:0] dbg_addr,
    output logic [7:0] dbg_data
);

    localparam logic [3:0]  OP_MUL = 4'b1110;
    localparam logic [3:0]  OP_CMP = 4'b1111;
    localparam int unsigned MAXLAT = (MUL_LAT > ALU_LAT) ? MUL_LAT : ALU_LAT;
    localparam int unsigned CW     = (MAXLAT > 1) ? $clog2(MAXLAT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        WB
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      rf_q [NREGS];
    logic [3:0]      fsl_q;
    logic [7:0]      a_q, b_q;
    logic [2:0]      rd_q;
    logic [CW-1:0]   cnt_q;
    logic [3:0]      flags_q;
    logic            done_q;

    logic            accept;
    logic            ld_en;
    logic            wb_en;
    logic [2:0]      rd_hi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    if (cnt_q == '0) state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Preload wins over issue in IDLE, so the two can never collide.
    always_comb begin
        instr_ready = (state_q == IDLE) && !ld_valid;
        accept      = instr_ready && instr_valid;
        ld_en       = (state_q == IDLE) && ld_valid;
        wb_en       = (state_q == WB);
    end

    assign rd_hi = (rd_q == 3'(NREGS - 1)) ? '0 : rd_q + 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_q    <= '{default: '0};
            fsl_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            flags_q <= '0;
            done_q  <= 1'b0;
        end else begin
            if (ld_en) begin
                rf_q[ld_addr] <= ld_data;
            end
            if (accept) begin
                fsl_q <= instr_op;
                a_q   <= rf_q[instr_rs1];
                b_q   <= rf_q[instr_rs2];
                rd_q  <= instr_rd;
                cnt_q <= (instr_op == OP_MUL) ? CW'(MUL_LAT - 1) : CW'(ALU_LAT - 1);
            end else if (state_q == EXEC && cnt_q != '0) begin
                cnt_q <= cnt_q - CW'(1);
            end
            if (wb_en) begin
                flags_q <= alu_sreg;
                if (fsl_q != OP_CMP) begin
                    rf_q[rd_q] <= alu_result;
                end
                if (fsl_q == OP_MUL) begin
                    rf_q[rd_hi] <= alu_mul_high;
                end
            end
            done_q <= wb_en;
        end
    end

    assign alu_fsl  = fsl_q;
    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign flags    = flags_q;
    assign done     = done_q;
    assign dbg_data = rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a registered ALU model on the far side
// and a scoreboard of expected writebacks popped on each done pulse.
module tb_alu_sequencer;

    localparam int unsigned ALU_LAT = 1;
    localparam int unsigned MUL_LAT = 2;

    logic       clk;
    logic       rst_n;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] instr_op;
    logic [2:0] instr_rd;
    logic [2:0] instr_rs1;
    logic [2:0] instr_rs2;
    logic       ld_valid;
    logic [2:0] ld_addr;
    logic [7:0] ld_data;
    logic [3:0] alu_fsl;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_result;
    logic [7:0] alu_mul_high;
    logic [3:0] alu_sreg;
    logic [3:0] flags;
    logic       done;
    logic [2:0] dbg_addr;
    logic [7:0] dbg_data;

    alu_sequencer #(
        .NREGS  (8),
        .ALU_LAT(ALU_LAT),
        .MUL_LAT(MUL_LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_rd    (instr_rd),
        .instr_rs1   (instr_rs1),
        .instr_rs2   (instr_rs2),
        .ld_valid    (ld_valid),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .alu_fsl     (alu_fsl),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_result  (alu_result),
        .alu_mul_high(alu_mul_high),
        .alu_sreg    (alu_sreg),
        .flags       (flags),
        .done        (done),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {V,S,C,Z, mul_high, result}.
    function automatic logic [19:0] alu_f(input logic [3:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
        logic [8:0]  s;
        logic [15:0] p;
        logic [7:0]  lo, hi;
        logic        v, n, c, z;
        s = '0; p = '0; lo = '0; hi = '0; v = 1'b0; c = 1'b0;
        case (op)
            4'b0000: begin
                s  = {1'b0, a} + {1'b0, b};
                lo = s[7:0]; c = s[8];
                v  = (a[7] == b[7]) && (lo[7] != a[7]);
            end
            4'b0001, 4'b1111: begin
                s  = {1'b0, a} - {1'b0, b};
                lo = s[7:0]; c = s[8];
                v  = (a[7] != b[7]) && (lo[7] != a[7]);
            end
            4'b0010: lo = a & b;
            4'b0011: lo = a | b;
            4'b0100: lo = a ^ b;
            4'b1110: begin
                p  = 16'(a) * 16'(b);
                lo = p[7:0]; hi = p[15:8];
            end
            default: lo = a;
        endcase
        if (op == 4'b1110) begin
            n = 1'b0; z = (p == 16'h0000);
        end else begin
            n = lo[7]; z = (lo == 8'h00);
        end
        return {v, n, c, z, hi, lo};
    endfunction

    always @(posedge clk) begin
        {alu_sreg, alu_mul_high, alu_result} <= alu_f(alu_fsl, alu_a, alu_b);
    end

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  rd;
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [3:0]  fl;
        int unsigned lat;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] shadow [8];
    logic [3:0] exp_flags;
    int         total;
    int         bad;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic check_rf(input string tag);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            dbg_addr = 3'(i);
            #1;
            chk($sformatf("%s_r%0d", tag, i), {8'h00, dbg_data}, {8'h00, shadow[i]});
        end
    endtask

    task automatic do_ld(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        ld_valid = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_valid = 1'b0;
        shadow[a] = d;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8; i++) shadow[i] = 8'h00;
        exp_flags = 4'h0;
    endtask

    task automatic issue(input string tag, input logic [3:0] op, input logic [2:0] rd,
                         input logic [2:0] rs1, input logic [2:0] rs2, input bit hold,
                         input bit with_ld, input logic [2:0] la, input logic [7:0] ldd);
        exp_t        e;
        logic [19:0] r;
        logic [7:0]  ea, eb;
        int          seen;
        int          rlow;
        bit          found;
        @(negedge clk);
        instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
        if (with_ld) begin
            ld_valid = 1'b1; ld_addr = la; ld_data = ldd;
            #1;
            chk({tag, "_ready_during_ld"}, {15'h0, instr_ready}, 16'h0);
            @(negedge clk);
            ld_valid = 1'b0;
            shadow[la] = ldd;
        end
        #1;
        chk({tag, "_ready_pre"}, {15'h0, instr_ready}, 16'h1);
        ea = shadow[rs1];
        eb = shadow[rs2];
        r  = alu_f(op, ea, eb);
        e.op = op; e.rd = rd; e.lo = r[7:0]; e.hi = r[15:8]; e.fl = r[19:16];
        e.lat = (op == 4'b1110) ? MUL_LAT : ALU_LAT;
        sb.push_back(e);
        @(posedge clk);
        seen = -1; rlow = 0; found = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (!hold) instr_valid = 1'b0;
            #1;
            if (k == 0) begin
                chk({tag, "_fsl"}, {12'h0, alu_fsl}, {12'h0, op});
                chk({tag, "_a"}, {8'h0, alu_a}, {8'h0, ea});
                chk({tag, "_b"}, {8'h0, alu_b}, {8'h0, eb});
            end
            if (done) begin
                seen = k; found = 1'b1; instr_valid = 1'b0;
                chk({tag, "_a_held"}, {8'h0, alu_a}, {8'h0, ea});
                chk({tag, "_b_held"}, {8'h0, alu_b}, {8'h0, eb});
                break;
            end
            if (!instr_ready) rlow++;
        end
        e = sb.pop_front();
        chk({tag, "_done_seen"}, {15'h0, found}, 16'h1);
        chk({tag, "_done_cycle"}, 16'(seen), 16'(e.lat + 1));
        chk({tag, "_ready_low_cycles"}, 16'(rlow), 16'(e.lat + 1));
        @(negedge clk);
        #1;
        chk({tag, "_done_one_pulse"}, {15'h0, done}, 16'h0);
        chk({tag, "_ready_after"}, {15'h0, instr_ready}, 16'h1);
        if (e.op != 4'b1111) shadow[e.rd] = e.lo;
        if (e.op == 4'b1110) shadow[3'(e.rd + 3'd1)] = e.hi;
        exp_flags = e.fl;
        chk({tag, "_flags"}, {12'h0, flags}, {12'h0, exp_flags});
        check_rf(tag);
        chk({tag, "_no_done_later"}, {15'h0, done}, 16'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0; instr_valid = 1'b0; instr_op = '0; instr_rd = '0;
        instr_rs1 = '0; instr_rs2 = '0; ld_valid = 1'b0; ld_addr = '0;
        ld_data = '0; dbg_addr = '0;
        clear_model();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_ready", {15'h0, instr_ready}, 16'h1);
        chk("reset_done", {15'h0, done}, 16'h0);
        chk("reset_flags", {12'h0, flags}, 16'h0);
        chk("reset_alu_a", {8'h0, alu_a}, 16'h0);

        // Reset in the middle of a preload sequence
        do_ld(3'd1, 8'h33);
        do_ld(3'd5, 8'h77);
        @(negedge clk);
        ld_valid = 1'b1; ld_addr = 3'd6; ld_data = 8'h99;
        rst_n = 1'b0;
        #1;
        chk("midreset_ready_held_low", {15'h0, instr_ready}, 16'h0);
        @(negedge clk);
        ld_valid = 1'b0;
        rst_n = 1'b1;
        clear_model();
        #1;
        chk("midreset_ready", {15'h0, instr_ready}, 16'h1);
        chk("midreset_done", {15'h0, done}, 16'h0);
        chk("midreset_flags", {12'h0, flags}, 16'h0);
        check_rf("midreset");

        do_ld(3'd1, 8'h0F);
        do_ld(3'd2, 8'h01);
        check_rf("preload");

        // ADD with carry-out wrap to zero
        do_ld(3'd1, 8'hFF);
        issue("add_wrap", 4'b0000, 3'd3, 3'd1, 3'd2, 1'b0, 1'b0, 3'd0, 8'h00);
        chk("add_wrap_flags_lit", {12'h0, flags}, 16'h0003);

        // MULTIPLY into r7, high byte wraps to r0
        do_ld(3'd4, 8'h10);
        do_ld(3'd5, 8'h10);
        issue("mul_wrap", 4'b1110, 3'd7, 3'd4, 3'd5, 1'b0, 1'b0, 3'd0, 8'h00);
        dbg_addr = 3'd0; #1;
        chk("mul_r0_lit", {8'h0, dbg_data}, 16'h0001);

        // COMPARE leaves the register file alone
        do_ld(3'd1, 8'h55);
        do_ld(3'd2, 8'h55);
        issue("cmp", 4'b1111, 3'd6, 3'd1, 3'd2, 1'b0, 1'b0, 3'd0, 8'h00);
        chk("cmp_flags_lit", {12'h0, flags}, 16'h0001);

        // Preload and issue together, instr_valid held through EXEC/WB
        issue("prio_sub", 4'b0001, 3'd2, 3'd1, 3'd2, 1'b1, 1'b1, 3'd1, 8'h10);

        issue("xor_rd_eq_rs1", 4'b0100, 3'd4, 3'd4, 3'd2, 1'b0, 1'b0, 3'd0, 8'h00);
        issue("or", 4'b0011, 3'd5, 3'd5, 3'd0, 1'b1, 1'b0, 3'd0, 8'h00);

        // Reset during EXEC aborts the ADD into r3
        do_ld(3'd3, 8'hAA);
        do_ld(3'd1, 8'h01);
        do_ld(3'd2, 8'h02);
        @(negedge clk);
        instr_valid = 1'b1; instr_op = 4'b0000; instr_rd = 3'd3;
        instr_rs1 = 3'd1; instr_rs2 = 3'd2;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        #1;
        chk("abort_in_exec", {15'h0, instr_ready}, 16'h0);
        rst_n = 1'b0;
        clear_model();
        #1;
        chk("abort_flags_async", {12'h0, flags}, 16'h0);
        chk("abort_alu_a_async", {8'h0, alu_a}, 16'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("abort_no_done_%0d", k), {15'h0, done}, 16'h0);
        end
        chk("abort_ready", {15'h0, instr_ready}, 16'h1);
        chk("abort_flags", {12'h0, flags}, 16'h0);
        check_rf("abort");
        chk("sb_empty", 16'(sb.size()), 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Issue and writeback controller that drives the 8-bit ALU from the other side of its fsl/A/B/result/SREG interface.
- Accepts one instruction at a time over a valid/ready handshake and reads operands from a local register file.
- Holds fsl/A/B stable while the registered ALU computes, then captures result, mul_high and SREG, writes the register file and the flag register, and pulses done.

Parameters:
- NREGS, 8: register-file depth; register addresses are 3 bits.
- ALU_LAT, 1: EXEC cycles for all opcodes except MULTIPLY (1110).
- MUL_LAT, 2: EXEC cycles for MULTIPLY.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  instruction request.
- instr_ready  out  1  instruction accepted when valid && ready at a rising edge.
- instr_op  in  4  ALU opcode, passed to alu_fsl.
- instr_rd  in  3  destination register.
- instr_rs1  in  3  source register for A.
- instr_rs2  in  3  source register for B.
- ld_valid  in  1  register preload request.
- ld_addr  in  3  preload address.
- ld_data  in  8  preload data.
- alu_fsl  out  4  to ALU fsl.
- alu_a  out  8  to ALU A.
- alu_b  out  8  to ALU B.
- alu_result  in  8  from ALU result.
- alu_mul_high  in  8  from ALU mul_high.
- alu_sreg  in  4  from ALU SREG, bit order {V,S,C,Z}.
- flags  out  4  latched SREG of the last completed instruction.
- done  out  1  one-cycle pulse after writeback.
- dbg_addr  in  3  debug read address.
- dbg_data  out  8  combinational read of rf[dbg_addr].

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE; all rf entries, flags, alu_fsl, alu_a, alu_b = 0; done = 0; counter = 0.
  - Reset mid-operation aborts the instruction: no register or flag write, no done.
- States: IDLE, EXEC, WB.
- IDLE:
  - instr_ready = (state==IDLE) && !ld_valid.
  - ld_valid has priority: rf[ld_addr] <= ld_data at the edge; state stays IDLE.
  - ld_valid is ignored outside IDLE.
  - On accept: alu_fsl <= instr_op, alu_a <= rf[rs1], alu_b <= rf[rs2]; rd is latched; counter <= latency-1 (MUL_LAT for 1110, else ALU_LAT); state <= EXEC.
- EXEC:
  - alu_fsl/alu_a/alu_b held constant.
  - Counter decrements each cycle; at 0, state <= WB.
- WB (one cycle), operands still held, alu_result/alu_sreg valid. At the closing edge:
  - flags <= alu_sreg for every opcode.
  - Opcodes 0000-1101: rf[rd] <= alu_result.
  - 1110 MULTIPLY: rf[rd] <= alu_result (low byte); rf[(rd+1) mod NREGS] <= alu_mul_high. If rd=7, the high byte goes to r0.
  - 1111 COMPARE: no register write.
  - done <= 1 for exactly one cycle; state <= IDLE.
- Latency: accept at edge E0, writeback at edge E(LAT+1), done high during cycle LAT+1.
  - Earliest next accept is at edge E(LAT+2), so the rate is 1 instruction per LAT+2 cycles.
- Operands are sampled at accept; rd == rs1/rs2 is legal, with the write occurring after the read.
- instr_* values are ignored unless accepted; holding instr_valid while not ready must not cause a double issue.
- done and instr_ready are never high in the same cycle as a writeback edge conflict; no ld/writeback collision is possible.
- dbg_data reflects writes in the cycle after the edge that performs them.
- flags hold their value between instructions; ld does not modify flags.

Test Plan:
- Reset/preload: assert rst_n=0 mid-sequence.
  - Required: all rf=0, flags=0, done=0, instr_ready=1 after release.
  - Then ld r1=0x0F, r2=0x01 -> dbg_data r1=0x0F, r2=0x01.
- ADD wrap: r1=0xFF, r2=0x01, ADD (0000) rd=r3 with ALU_LAT=1.
  - Required: done at cycle 2 after accept, r3=0x00, flags=4'b0011 (C=1, Z=1).
  - instr_ready low for exactly 2 cycles.
- MULTIPLY: r4=0x10, r5=0x10, op 1110 rd=r7 with MUL_LAT=2.
  - Required: r7=0x00, r0=0x01 (wrap), flags=4'b0000, done at cycle 3 after accept.
- COMPARE: op 1111 with r1=r2=0x55.
  - Required: no rf change (check all 8 entries), flags updated to alu_sreg, done pulses once.
- Handshake priority: assert ld_valid and instr_valid together in IDLE.
  - Required: ld performed, instr_ready=0 that cycle; instruction accepted the next cycle.
  - Also: instr_valid held through EXEC/WB issues exactly once.
- Abort: assert rst_n=0 during EXEC of ADD into r3 (r3 preloaded 0xAA).
  - Required: no done; r3=0x00 from reset, not the ADD result; state IDLE.
